// File: rtl/mem_to_sram_responder.sv
// mem_to_sram_responder
// Bridges a valid/ready memory request stream onto a single-ported SRAM and
// returns one response per accepted request, in order, after a fixed latency.
// Requests outside [0, MemBytes) never reach the SRAM and are answered with
// err=1 after the same latency.
// Optional feature: define MEM_RESP_OUTREG_EN to add one register stage on
// all mem_resp_* outputs (response latency becomes Latency+1).
module mem_to_sram_responder #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4,
    parameter int Latency   = 1,
    parameter int MemBytes  = 65536
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    // request stream
    input  logic                            mem_req_valid_i,
    output logic                            mem_req_ready_o,
    input  logic [AddrWidth-1:0]            mem_req_addr_i,
    input  logic                            mem_req_we_i,
    input  logic [DataWidth/8-1:0]          mem_req_be_i,
    input  logic [DataWidth-1:0]            mem_req_wdata_i,
    input  logic [IdWidth-1:0]              mem_req_id_i,
    // response stream (no back-pressure)
    output logic                            mem_resp_valid_o,
    output logic [DataWidth-1:0]            mem_resp_rdata_o,
    output logic [IdWidth-1:0]              mem_resp_id_o,
    output logic                            mem_resp_err_o,
    // SRAM port
    output logic                            sram_req_o,
    input  logic                            sram_gnt_i,
    output logic                            sram_we_o,
    output logic [AddrWidth-1:0]            sram_addr_o,
    output logic [DataWidth/8-1:0]          sram_be_o,
    output logic [DataWidth-1:0]            sram_wdata_o,
    input  logic [DataWidth-1:0]            sram_rdata_i,
    // accepted requests still awaiting their response
    output logic [$clog2(Latency+2)-1:0]    outstanding_o
);

    localparam int OutWidth = $clog2(Latency + 2);
    localparam logic [AddrWidth:0]  MemLimit = (AddrWidth + 1)'(MemBytes);
    localparam logic [OutWidth-1:0] OneCnt   = OutWidth'(1);

    logic                   w_in_range;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_resp_fire;

    // Tag pipeline: one entry per cycle, index Latency-1 is the response stage.
    logic [Latency-1:0]              r_vld;
    logic [Latency-1:0][IdWidth-1:0] r_id;
    logic [Latency-1:0]              r_we;
    logic [Latency-1:0]              r_err;
    logic [OutWidth-1:0]             r_outstanding;

    // Response-stage view, zeroed whenever the stage holds no request.
    logic                   w_st_vld;
    logic [IdWidth-1:0]     w_st_id;
    logic                   w_st_err;
    logic [DataWidth-1:0]   w_st_rdata;

    // Compare one bit wider than the address so MemBytes = 2**AddrWidth works.
    assign w_in_range = ({1'b0, mem_req_addr_i} < MemLimit);

    // SRAM side is a pure pass-through; out-of-range requests are kept off it.
    assign sram_req_o   = mem_req_valid_i & w_in_range;
    assign sram_we_o    = mem_req_we_i;
    assign sram_addr_o  = mem_req_addr_i;
    assign sram_be_o    = mem_req_be_i;
    assign sram_wdata_o = mem_req_wdata_i;

    // Ready: blocked in reset, follows grant in range, always ready for errors.
    always_comb begin
        w_ready = 1'b0;
        if (!rst_ni) begin
            w_ready = 1'b0;
        end else if (w_in_range) begin
            w_ready = sram_gnt_i;
        end else begin
            w_ready = 1'b1;
        end
    end

    assign mem_req_ready_o = w_ready;
    assign w_accept        = mem_req_valid_i & w_ready;

    // Non-stalling tag pipeline; stage 0 only records a request on acceptance.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vld <= '0;
            r_id  <= '0;
            r_we  <= '0;
            r_err <= '0;
        end else begin
            r_vld[0] <= w_accept;
            r_id[0]  <= w_accept ? mem_req_id_i : {IdWidth{1'b0}};
            r_we[0]  <= w_accept & mem_req_we_i;
            r_err[0] <= w_accept & ~w_in_range;
            for (int i = 1; i < Latency; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
                r_we[i]  <= r_we[i-1];
                r_err[i] <= r_err[i-1];
            end
        end
    end

    // Response stage: read data only for valid, in-range reads.
    always_comb begin
        w_st_vld   = r_vld[Latency-1];
        w_st_id    = {IdWidth{1'b0}};
        w_st_err   = 1'b0;
        w_st_rdata = {DataWidth{1'b0}};
        if (w_st_vld) begin
            w_st_id  = r_id[Latency-1];
            w_st_err = r_err[Latency-1];
            if (!r_we[Latency-1] && !r_err[Latency-1]) begin
                w_st_rdata = sram_rdata_i;
            end else begin
                w_st_rdata = {DataWidth{1'b0}};
            end
        end else begin
            w_st_rdata = {DataWidth{1'b0}};
        end
    end

`ifdef MEM_RESP_OUTREG_EN
    logic                   r_resp_valid;
    logic [DataWidth-1:0]   r_resp_rdata;
    logic [IdWidth-1:0]     r_resp_id;
    logic                   r_resp_err;

    // Extra output register; sram_rdata_i is captured at the response stage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= {DataWidth{1'b0}};
            r_resp_id    <= {IdWidth{1'b0}};
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_st_vld;
            r_resp_rdata <= w_st_rdata;
            r_resp_id    <= w_st_id;
            r_resp_err   <= w_st_err;
        end
    end

    assign mem_resp_valid_o = r_resp_valid;
    assign mem_resp_rdata_o = r_resp_rdata;
    assign mem_resp_id_o    = r_resp_id;
    assign mem_resp_err_o   = r_resp_err;
    assign w_resp_fire      = r_resp_valid;
`else
    assign mem_resp_valid_o = w_st_vld;
    assign mem_resp_rdata_o = w_st_rdata;
    assign mem_resp_id_o    = w_st_id;
    assign mem_resp_err_o   = w_st_err;
    assign w_resp_fire      = w_st_vld;
`endif

    // In-flight counter: +1 on acceptance, -1 on emitted response, hold on both.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_outstanding <= {OutWidth{1'b0}};
        end else begin
            case ({w_accept, w_resp_fire})
                2'b10:   r_outstanding <= r_outstanding + OneCnt;
                2'b01:   r_outstanding <= r_outstanding - OneCnt;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign outstanding_o = r_outstanding;

endmodule
